mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the core's memory-side blocks.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while fetch is waiting; saturates at MAX_WAIT
// and then raises force_if so fetch wins the next arbitration.
module arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       if_gnt,
  input  logic       d_gnt,
  output logic [3:0] count,
  output logic       force_if
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] count_d, count_q;

  // Next count: fetch served or not waiting clears; data grant while fetch waits bumps.
  always_comb begin
    count_d = count_q;
    if (if_gnt || !if_req) begin
      count_d = '0;
    end else if (d_gnt && (count_q < MaxWait)) begin
      count_d = count_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign force_if = (count_q == MaxWait);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of a single-port memory.
// One transaction outstanding at a time; data has priority unless fetch has starved.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // Instruction fetch (read only)
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // Data
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // Shared memory
  output logic            mem_req,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  // Status
  output logic            busy,
  output logic            err_spurious
);

  localparam int unsigned BW = DW / 8;

  arb_state_e state_d, state_q;
  owner_e     owner_d, owner_q;
  logic       err_d, err_q;

  logic       idle, sel_if, grant, rsp;
  logic [3:0] starve_cnt;
  logic       force_if;

  arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .count    (starve_cnt),
    .force_if (force_if)
  );

  assign idle   = (state_q == ARB_IDLE);
  assign sel_if = if_req & (~d_req | force_if);

  // Request side; rst gating keeps handshakes quiet while reset is held.
  assign mem_req   = rst & idle & (if_req | d_req);
  assign grant     = mem_req & mem_ready;
  assign if_gnt    = grant & sel_if;
  assign d_gnt     = grant & ~sel_if;
  assign mem_we    = sel_if ? 1'b0 : d_we;
  assign mem_be    = sel_if ? {BW{1'b1}} : d_be;
  assign mem_addr  = sel_if ? if_addr : d_addr;
  assign mem_wdata = d_wdata;

  // Response side: only the registered owner sees rvalid.
  assign rsp       = rst & ~idle & mem_rvalid;
  assign if_rvalid = rsp & (owner_q == OWN_IF);
  assign d_rvalid  = rsp & (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign busy         = ~idle;
  assign err_spurious = err_q;

  // Next-state: grant moves to BUSY, response returns to IDLE; stray rvalid is sticky error.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    if (idle) begin
      if (grant) begin
        state_d = ARB_BUSY;
        owner_d = sel_if ? OWN_IF : OWN_D;
      end
      if (mem_rvalid) begin
        err_d = 1'b1;
      end
    end else if (mem_rvalid) begin
      state_d = ARB_IDLE;
    end
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Counter must never run past its saturation point.
  assert property (@(posedge clk) disable iff (!rst) starve_cnt <= 4'(MAX_WAIT));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level reference model checked every cycle, directed
// scenarios for the key behaviours, then randomized traffic with resets and stray responses.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32, DW = 32, MAX_WAIT = 4, BW = DW / 8;

  logic          clk = 1'b0, rst = 1'b0;
  logic          if_req = 0, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          d_req = 0, d_we = 0, d_gnt, d_rvalid;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic          mem_req, mem_ready = 0, mem_we, mem_rvalid = 0;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic          busy, err_spurious;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, who owns it, how long fetch has waited.
  bit m_busy, m_owner_d, m_we, m_err, last_if_gnt, last_d_gnt;
  int m_starve, resp_cnt, cyc;
  bit e_fetch, e_grant, e_if_gnt, e_d_gnt;
  // Memory responder knobs.
  bit auto_resp = 1, resp_rand = 0, rand_lat = 0, spur_en = 0;
  int mem_lat = 1;
  logic [DW-1:0] resp_data = '0;

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_we = 0; m_err = 0; m_starve = 0;
    last_if_gnt = 0; last_d_gnt = 0; resp_cnt = 0;
  endtask

  // Compare every output with what the model predicts for the current inputs.
  task automatic settle();
    bit e_mem_req, e_if_rv, e_d_rv;
    #4;
    e_mem_req = !m_busy && (if_req || d_req);
    e_fetch   = if_req && (!d_req || m_starve == MAX_WAIT);
    e_grant   = e_mem_req && mem_ready;
    e_if_gnt  = e_grant && e_fetch;
    e_d_gnt   = e_grant && !e_fetch;
    e_if_rv   = m_busy && mem_rvalid && !m_owner_d;
    e_d_rv    = m_busy && mem_rvalid && m_owner_d;
    check_eq("mem_req", mem_req, e_mem_req);
    check_eq("if_gnt", if_gnt, e_if_gnt);
    check_eq("d_gnt", d_gnt, e_d_gnt);
    check_eq("if_rvalid", if_rvalid, e_if_rv);
    check_eq("d_rvalid", d_rvalid, e_d_rv);
    check_eq("busy", busy, m_busy);
    check_eq("err_spurious", err_spurious, m_err);
    if (e_mem_req) begin
      check_eq("mem_addr", mem_addr, e_fetch ? if_addr : d_addr);
      check_eq("mem_we", mem_we, e_fetch ? 1'b0 : d_we);
      check_eq("mem_be", mem_be, e_fetch ? {BW{1'b1}} : d_be);
      if (!e_fetch) check_eq("mem_wdata", mem_wdata, d_wdata);
    end
    if (e_if_rv) check_eq("if_rdata", if_rdata, mem_rdata);
    if (e_d_rv && !m_we) check_eq("d_rdata", d_rdata, mem_rdata);
  endtask

  // Clock edge: advance the model, then let the memory respond.
  task automatic tick();
    bit was_busy;
    @(posedge clk);
    was_busy = m_busy;
    if (was_busy && mem_rvalid) m_busy = 0;
    else if (e_grant) begin
      m_busy = 1; m_owner_d = !e_fetch; m_we = !e_fetch && d_we;
      resp_cnt = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
    end
    if (!was_busy && mem_rvalid) m_err = 1;
    if (e_if_gnt || !if_req) m_starve = 0;
    else if (e_d_gnt && m_starve < MAX_WAIT) m_starve++;
    last_if_gnt = e_if_gnt; last_d_gnt = e_d_gnt;
    cyc++;
    #1;
    if (auto_resp) begin
      mem_rvalid = 0;
      if (m_busy) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = resp_rand ? DW'($urandom) : resp_data;
        end
      end else if (spur_en && $urandom_range(0, 99) == 0) begin
        mem_rvalid = 1; mem_rdata = DW'($urandom);
      end
    end
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must drop without a clock edge.
  task automatic apply_reset(input int cycles);
    #1 rst = 0;
    #1;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_if_gnt", if_gnt, 1'b0);
    check_eq("rst_d_gnt", d_gnt, 1'b0);
    check_eq("rst_d_rvalid", d_rvalid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err_spurious, 1'b0);
    model_reset();
    mem_rvalid = 0;
    repeat (cycles) @(posedge clk);
    #2 rst = 1;
  endtask

  task automatic drain();
    if_req = 0; d_req = 0; mem_ready = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!m_busy) break;
    end
    check_eq("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got[$];
    bit exp_seq[6];
    int g0, last_rv, n_rv;
    exp_seq = '{0, 0, 0, 0, 1, 0};
    model_reset();
    cyc = 0;

    // Reset state with both requesters active.
    if_req = 1; d_req = 1; mem_ready = 1; mem_rvalid = 1;
    #3;
    check_eq("por_mem_req", mem_req, 1'b0);
    check_eq("por_gnt", {if_gnt, d_gnt}, 2'b00);
    check_eq("por_rvalid", {if_rvalid, d_rvalid}, 2'b00);
    check_eq("por_busy", busy, 1'b0);
    check_eq("por_err", err_spurious, 1'b0);
    mem_rvalid = 0; if_req = 0; d_req = 0;
    @(posedge clk); #1 rst = 1;

    // Fetch alone; usable in the very first cycle after release.
    if_req = 1; if_addr = 'h10; resp_data = 'h00500093; mem_lat = 1;
    settle();
    check_eq("f_if_gnt", if_gnt, 1'b1);
    check_eq("f_mem_addr", mem_addr, 'h10);
    tick(); if_req = 0;
    settle();
    check_eq("f_gnt_pulse", if_gnt, 1'b0);
    check_eq("f_if_rvalid", if_rvalid, 1'b1);
    check_eq("f_if_rdata", if_rdata, 'h00500093);
    check_eq("f_d_rvalid", d_rvalid, 1'b0);
    tick();
    drain();

    // Collision: data first, fetch two cycles later.
    if_req = 1; if_addr = 'h20; d_req = 1; d_we = 1; d_be = '1; d_addr = 'h8; d_wdata = 12;
    settle();
    check_eq("c_d_gnt", d_gnt, 1'b1);
    check_eq("c_if_gnt0", if_gnt, 1'b0);
    check_eq("c_mem_we", mem_we, 1'b1);
    check_eq("c_mem_addr", mem_addr, 'h8);
    tick(); d_req = 0;
    step();
    settle();
    check_eq("c_if_gnt2", if_gnt, 1'b1);
    tick(); if_req = 0;
    drain();

    // Starvation: four data grants, then fetch, then data again.
    if_req = 1; d_req = 1; d_we = 0;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      settle();
      if (if_gnt) got.push_back(1'b1);
      if (d_gnt) got.push_back(1'b0);
      tick();
      if (last_if_gnt) if_req = 0;
    end
    check_eq("s_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) check_eq($sformatf("s_grant%0d", i), got[i], exp_seq[i]);
    drain();

    // Back-pressure: no grant while mem_ready is low.
    d_req = 1; mem_ready = 0;
    repeat (3) begin
      settle();
      check_eq("bp_no_gnt", d_gnt, 1'b0);
      check_eq("bp_idle", busy, 1'b0);
      tick();
    end
    mem_ready = 1;
    settle();
    check_eq("bp_gnt", d_gnt, 1'b1);
    tick(); d_req = 0;
    drain();

    // Latency 3: ten back-to-back fetches span 40 cycles.
    mem_lat = 3; if_req = 1; if_addr = 'h100; g0 = -1; last_rv = -1; n_rv = 0;
    for (int c = 0; c < 100 && n_rv < 10; c++) begin
      settle();
      if (if_gnt && g0 < 0) g0 = cyc;
      if (if_rvalid) begin n_rv++; last_rv = cyc; end
      tick();
      if (n_rv == 10) if_req = 0;
      else if (last_if_gnt) if_addr = if_addr + 4;
    end
    check_eq("lat_n", n_rv, 10);
    check_eq("lat_cycles", last_rv - g0 + 1, 40);
    mem_lat = 1;
    drain();

    // Reset mid-flight; a late response is flagged, not forwarded.
    auto_resp = 0; mem_rvalid = 0; d_req = 1; d_we = 0; d_addr = 'h40;
    settle();
    check_eq("r_d_gnt", d_gnt, 1'b1);
    tick(); d_req = 0;
    settle();
    check_eq("r_busy", busy, 1'b1);
    tick();
    apply_reset(2);
    mem_rvalid = 1; mem_rdata = 'hdead;
    settle();
    check_eq("r_late_rvalid", d_rvalid, 1'b0);
    tick(); mem_rvalid = 0;
    settle();
    check_eq("r_err", err_spurious, 1'b1);
    check_eq("r_busy_after", busy, 1'b0);
    tick();
    auto_resp = 1;

    // Randomized traffic.
    resp_rand = 1; rand_lat = 1; spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(0, 299) == 0) apply_reset(1);
      if (last_if_gnt || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = AW'($urandom);
      end
      if (last_d_gnt || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom);
        d_be = BW'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
